// File: rtl/bitmask_index_iter.sv
// Set-bit enumerator: accepts a mask and emits the absolute position of every set bit,
// one per output handshake, in ascending (MODE=0) or descending (MODE=1) order.

module bitmask_index_iter_lzc #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    // MODE=0 counts trailing zeros, MODE=1 counts leading zeros; all-zero input yields 0.
    always_comb begin
        logic found;
        cnt_o = '0;
        found = 1'b0;
        if (!MODE) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (!found && in_i[i]) begin
                    cnt_o = CNT_WIDTH'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (!found && in_i[i]) begin
                    cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
                    found = 1'b1;
                end
            end
        end
    end
endmodule

module bitmask_index_iter #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 mask_valid_i,
    output logic                 mask_ready_o,
    input  logic [WIDTH-1:0]     mask_i,
    output logic                 idx_valid_o,
    input  logic                 idx_ready_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 last_o,
    output logic                 busy_o
);
    typedef enum logic {IDLE, ITER} state_e;

    localparam logic [WIDTH-1:0]     ONE = WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] TOP = IDX_WIDTH'(WIDTH - 1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic [IDX_WIDTH-1:0]  cnt;
    logic [IDX_WIDTH-1:0]  pos;
    logic                  single;
    logic                  iter;

    bitmask_index_iter_lzc #(
        .WIDTH    (WIDTH),
        .MODE     (MODE),
        .CNT_WIDTH(IDX_WIDTH)
    ) u_lzc (
        .in_i (res_q),
        .cnt_o(cnt)
    );

    // Descending mode reports the absolute position, not the leading-zero count.
    assign pos    = MODE ? (TOP - cnt) : cnt;
    assign single = ((res_q & (res_q - ONE)) == '0);
    assign iter   = (state_q == ITER);

    assign mask_ready_o = (state_q == IDLE);
    assign idx_valid_o  = iter;
    assign busy_o       = iter;
    assign idx_o        = iter ? pos : '0;
    assign last_o       = iter & single;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (mask_valid_i && (mask_i != '0)) begin
                    state_d = ITER;
                    res_d   = mask_i;
                end
            end
            ITER: begin
                if (idx_ready_i) begin
                    if (single) begin
                        state_d = IDLE;
                        res_d   = '0;
                    end else begin
                        res_d = res_q & ~(ONE << pos);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                res_d   = '0;
            end
        endcase
        // Abort wins over any handshake; a coincident mask is consumed and dropped.
        if (flush_i) begin
            state_d = IDLE;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

`ifndef SYNTHESIS
    a_width_pos : assert property (@(posedge clk_i) WIDTH > 0);

    a_valid_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
        idx_valid_o |-> (res_q != '0));

    a_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (idx_valid_o && !idx_ready_i && !flush_i) |=> ($stable(idx_o) && $stable(last_o) && idx_valid_o));
`endif
endmodule

// File: tb/tb_bitmask_index_iter.sv
// Directed bench for bitmask_index_iter: ascending/descending order, backpressure,
// empty masks, flush, mid-iteration reset, back-to-back masks and WIDTH=1.
`timescale 1ns/1ps

module tb_bitmask_index_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        mvalid = 1'b0;
    logic [15:0] mask = '0;
    logic        iready = 1'b0;

    logic       mrdy0, ivld0, last0, busy0;
    logic [3:0] idx0;
    logic       mrdy1, ivld1, last1, busy1;
    logic [3:0] idx1;
    logic       mrdyw, ivldw, lastw, busyw;
    logic [0:0] idxw;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bitmask_index_iter #(.WIDTH(16), .MODE(1'b0)) dut_asc (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .mask_valid_i(mvalid), .mask_ready_o(mrdy0), .mask_i(mask),
        .idx_valid_o(ivld0), .idx_ready_i(iready), .idx_o(idx0),
        .last_o(last0), .busy_o(busy0)
    );

    bitmask_index_iter #(.WIDTH(16), .MODE(1'b1)) dut_desc (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .mask_valid_i(mvalid), .mask_ready_o(mrdy1), .mask_i(mask),
        .idx_valid_o(ivld1), .idx_ready_i(iready), .idx_o(idx1),
        .last_o(last1), .busy_o(busy1)
    );

    bitmask_index_iter #(.WIDTH(1), .MODE(1'b0)) dut_w1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .mask_valid_i(mvalid), .mask_ready_o(mrdyw), .mask_i(mask[0:0]),
        .idx_valid_o(ivldw), .idx_ready_i(iready), .idx_o(idxw),
        .last_o(lastw), .busy_o(busyw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({mrdy0, ivld0, busy0, last0, idx0} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_asc: got %b required %b", {mrdy0, ivld0, busy0, last0, idx0}, 8'b1000_0000);
        end
        n_checks++;
        if ({mrdy1, ivld1, busy1, last1, idx1} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_desc: got %b required %b", {mrdy1, ivld1, busy1, last1, idx1}, 8'b1000_0000);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Mask 0x8421 with continuous ready: checks both orderings at once.
    task automatic test_order();
        logic [3:0] exp_asc [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        logic [3:0] exp_desc[4] = '{4'd15, 4'd10, 4'd5, 4'd0};
        mask = 16'h8421; mvalid = 1'b1; iready = 1'b1;
        tick();
        mvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({ivld0, last0, idx0} !== {1'b1, k == 3, exp_asc[k]}) begin
                n_fail++;
                $display("FAIL asc_beat%0d: got v=%0d l=%0d i=%0d required v=1 l=%0d i=%0d",
                         k, ivld0, last0, idx0, k == 3, exp_asc[k]);
            end
            n_checks++;
            if ({ivld1, last1, idx1} !== {1'b1, k == 3, exp_desc[k]}) begin
                n_fail++;
                $display("FAIL desc_beat%0d: got v=%0d l=%0d i=%0d required v=1 l=%0d i=%0d",
                         k, ivld1, last1, idx1, k == 3, exp_desc[k]);
            end
            tick();
        end
        n_checks++;
        if ({mrdy0, ivld0, mrdy1, ivld1} !== 4'b1010) begin
            n_fail++;
            $display("FAIL order_done: got %b required 1010", {mrdy0, ivld0, mrdy1, ivld1});
        end
    endtask

    task automatic test_full();
        int k = 0;
        int cycles = 0;
        mask = 16'hFFFF; mvalid = 1'b1; iready = 1'b1;
        tick();
        mvalid = 1'b0;
        while (busy0 && cycles < 40) begin
            n_checks++;
            if ({ivld0, last0, idx0} !== {1'b1, k == 15, 4'(k)}) begin
                n_fail++;
                $display("FAIL full_beat%0d: got l=%0d i=%0d required l=%0d i=%0d",
                         k, last0, idx0, k == 15, k);
            end
            k++;
            cycles++;
            tick();
        end
        n_checks++;
        if (k !== 16) begin
            n_fail++;
            $display("FAIL full_busy_cycles: got %0d required 16", k);
        end
    endtask

    task automatic test_backpressure();
        mask = 16'h0012; mvalid = 1'b1; iready = 1'b0;
        tick();
        mvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({ivld0, last0, idx0} !== {1'b1, 1'b0, 4'd1}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%0d l=%0d i=%0d required v=1 l=0 i=1",
                         k, ivld0, last0, idx0);
            end
            tick();
        end
        iready = 1'b1;
        n_checks++;
        if ({ivld0, last0, idx0} !== {1'b1, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL bp_release: got v=%0d l=%0d i=%0d required v=1 l=0 i=1", ivld0, last0, idx0);
        end
        tick();
        n_checks++;
        if ({ivld0, last0, idx0} !== {1'b1, 1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL bp_last: got v=%0d l=%0d i=%0d required v=1 l=1 i=4", ivld0, last0, idx0);
        end
        tick();
        n_checks++;
        if ({mrdy0, ivld0} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_done: got %b required 10", {mrdy0, ivld0});
        end
    endtask

    task automatic test_zero_mask();
        mask = 16'h0000; mvalid = 1'b1; iready = 1'b1;
        tick();
        n_checks++;
        if ({mrdy0, ivld0, busy0} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_mask: got %b required 100", {mrdy0, ivld0, busy0});
        end
        mask = 16'h0001;
        tick();
        mvalid = 1'b0;
        n_checks++;
        if ({ivld0, last0, idx0} !== {1'b1, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL after_zero: got v=%0d l=%0d i=%0d required v=1 l=1 i=0", ivld0, last0, idx0);
        end
        tick();
    endtask

    task automatic test_flush();
        mask = 16'h00F0; mvalid = 1'b1; iready = 1'b1;
        tick();
        mvalid = 1'b0;
        n_checks++;
        if ({ivld0, idx0} !== {1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL flush_first: got v=%0d i=%0d required v=1 i=4", ivld0, idx0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({ivld0, mrdy0, busy0} !== 3'b010) begin
            n_fail++;
            $display("FAIL flush_idle: got %b required 010", {ivld0, mrdy0, busy0});
        end
        mask = 16'h0100; mvalid = 1'b1;
        tick();
        mvalid = 1'b0;
        n_checks++;
        if ({ivld0, last0, idx0} !== {1'b1, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL flush_next: got v=%0d l=%0d i=%0d required v=1 l=1 i=8", ivld0, last0, idx0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        mask = 16'hAAAA; mvalid = 1'b1; iready = 1'b1;
        tick();
        mvalid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({ivld0, mrdy0, busy0} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_mid: got %b required 010", {ivld0, mrdy0, busy0});
        end
        mask = 16'h0003; mvalid = 1'b1;
        tick();
        mvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({ivld0, last0, idx0} !== {1'b1, k == 1, 4'(k)}) begin
                n_fail++;
                $display("FAIL reset_fresh%0d: got v=%0d l=%0d i=%0d required v=1 l=%0d i=%0d",
                         k, ivld0, last0, idx0, k == 1, k);
            end
            tick();
        end
    endtask

    // mask_valid held high across the last beat: the next mask must wait for a bubble.
    task automatic test_back_to_back();
        mask = 16'h0003; mvalid = 1'b1; iready = 1'b1;
        tick();
        mask = 16'h0004;
        n_checks++;
        if ({mrdy0, ivld0, idx0} !== {1'b0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL b2b_beat0: got r=%0d v=%0d i=%0d required r=0 v=1 i=0", mrdy0, ivld0, idx0);
        end
        tick();
        n_checks++;
        if ({mrdy0, ivld0, last0, idx0} !== {1'b0, 1'b1, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL b2b_last: got r=%0d v=%0d l=%0d i=%0d required r=0 v=1 l=1 i=1",
                     mrdy0, ivld0, last0, idx0);
        end
        tick();
        n_checks++;
        if ({mrdy0, ivld0} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_bubble: got %b required 10", {mrdy0, ivld0});
        end
        tick();
        mvalid = 1'b0;
        n_checks++;
        if ({ivld0, last0, idx0} !== {1'b1, 1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%0d l=%0d i=%0d required v=1 l=1 i=2", ivld0, last0, idx0);
        end
        tick();
    endtask

    task automatic test_width1();
        n_checks++;
        if ({mrdyw, ivldw, lastw, idxw} !== 4'b1000) begin
            n_fail++;
            $display("FAIL w1_idle: got %b required 1000", {mrdyw, ivldw, lastw, idxw});
        end
        mask = 16'h0001; mvalid = 1'b1; iready = 1'b1;
        tick();
        mvalid = 1'b0;
        n_checks++;
        if ({ivldw, lastw, idxw, busyw} !== 4'b1101) begin
            n_fail++;
            $display("FAIL w1_beat: got %b required 1101", {ivldw, lastw, idxw, busyw});
        end
        tick();
        n_checks++;
        if ({mrdyw, ivldw, busyw} !== 3'b100) begin
            n_fail++;
            $display("FAIL w1_done: got %b required 100", {mrdyw, ivldw, busyw});
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_backpressure();
        test_zero_mask();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
